// File: rtl/vr_usr_pkg.sv
// vr_usr_pkg: mode encodings, controller states and the shift-class helper shared by vr_univ_shreg
package vr_usr_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_CLR  = 3'b110;
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  function automatic logic is_shift_mode(input logic [2:0] m);
    return m inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL};
  endfunction
endpackage

// File: rtl/vr_usr_step.sv
// vr_usr_step: combinational next register value for one application of a mode
module vr_usr_step import vr_usr_pkg::*; #(
  parameter int W = 4
) (
  input  logic [2:0]   mode,
  input  logic [W-1:0] q,
  input  logic         lin,
  input  logic         rin,
  input  logic [W-1:0] din,
  output logic [W-1:0] q_next
);
  always_comb
    q_next = mode == MODE_HOLD ? q :
             mode == MODE_SHR  ? {q[W-2:0], rin} :
             mode == MODE_SHL  ? {lin, q[W-1:1]} :
             mode == MODE_LOAD ? din :
             mode == MODE_ROR  ? {q[W-2:0], q[W-1]} :
             mode == MODE_ROL  ? {q[0], q[W-1:1]} :
             mode == MODE_CLR  ? '0 : q;
endmodule

// File: rtl/vr_univ_shreg.sv
// vr_univ_shreg: parametrised universal shift register with rotate modes and START/BUSY/DONE burst shifting
// Optional serial outputs and ZERO flag under VR_USR_SEROUT_EN.
module vr_univ_shreg import vr_usr_pkg::*; #(
  parameter int W  = 4,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          EN,
  input  logic [2:0]    MODE,
  input  logic          LIN,
  input  logic          RIN,
  input  logic [W-1:0]  DIN,
  input  logic          START,
  input  logic [AW-1:0] AMT,
  output logic [W-1:0]  Q,
  output logic          BUSY,
`ifdef VR_USR_SEROUT_EN
  output logic          DONE,
  output logic          SOUT_R,
  output logic          SOUT_L,
  output logic          ZERO
`else
  output logic          DONE
`endif
);
  state_t state, state_d;
  logic [2:0] lmode;
  logic [AW-1:0] cnt, cnt_d;
  logic [W-1:0] q_step, q_d;
  logic burst;
  vr_usr_step #(.W(W)) u_step (
    .mode(state == RUN ? lmode : MODE),
    .q(Q),
    .lin(LIN),
    .rin(RIN),
    .din(DIN),
    .q_next(q_step)
  );
  // a burst takes its first step on the START edge, so cnt holds the steps still owed
  always_comb begin
    burst = START && is_shift_mode(MODE);
    state_d = state;
    cnt_d = cnt;
    q_d = Q;
    case (state)
      IDLE: begin
        q_d = (burst ? AMT != '0 : START || EN) ? q_step : Q;
        cnt_d = burst ? AMT - AW'(1) : cnt;
        state_d = !burst ? IDLE : AMT > AW'(1) ? RUN : FIN;
      end
      RUN: begin
        q_d = q_step;
        cnt_d = cnt - AW'(1);
        state_d = cnt == AW'(1) ? FIN : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) begin
      Q <= '0;
      state <= IDLE;
      cnt <= '0;
      lmode <= MODE_HOLD;
      BUSY <= 1'b0;
      DONE <= 1'b0;
    end else begin
      Q <= q_d;
      state <= state_d;
      cnt <= cnt_d;
      lmode <= state == IDLE && burst ? MODE : lmode;
      BUSY <= state_d != IDLE;
      DONE <= state_d == FIN;
    end
`ifdef VR_USR_SEROUT_EN
  assign SOUT_R = Q[W-1];
  assign SOUT_L = Q[0];
  always_ff @(posedge CLK or posedge CLR)
    if (CLR) ZERO <= 1'b1;
    else ZERO <= q_d == '0;
`endif
endmodule
